// File: rtl/chirp_sweep_gen.sv
// chirp_sweep_gen
//   Linear-chirp core. A frequency word ramps between two bounds in one of
//   four sweep modes, holding each value for dwell+1 enabled cycles, while a
//   phase accumulator integrates it. The top bits of the phase are presented
//   as a sawtooth and a square wave.
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   ena       clock enable; low freezes every register, including done
//   start     begin a sweep (accepted only when idle)
//   stop      abort a sweep and return to idle (wins over start)
//   mode      0 single-up, 1 repeat-up, 2 triangle, 3 single-down
//   f_start   lower frequency bound
//   f_stop    upper frequency bound
//   f_step    frequency increment per step
//   dwell     each frequency is held for dwell+1 enabled cycles
//   busy      sweep in progress
//   done      one-cycle pulse at the end of a sweep or leg
//   freq_out  current frequency word
//   saw_out   top OUT_W bits of the phase accumulator
//   sq_out    MSB of the phase accumulator
module chirp_sweep_gen #(
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 12,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic               done,
  output logic [FREQ_W-1:0]  freq_out,
  output logic [OUT_W-1:0]   saw_out,
  output logic               sq_out
);

  localparam logic [1:0] MODE_SINGLE_UP = 2'd0;
  localparam logic [1:0] MODE_REPEAT_UP = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE  = 2'd2;
  localparam logic [1:0] MODE_SINGLE_DN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [FREQ_W-1:0]    freq_q, freq_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Sweep configuration captured at start; inputs are ignored while busy.
  logic [1:0]           mode_q, mode_d;
  logic [FREQ_W-1:0]    f_start_q, f_start_d;
  logic [FREQ_W-1:0]    f_stop_q, f_stop_d;
  logic [FREQ_W-1:0]    f_step_q, f_step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  // Step arithmetic is one bit wider so overflow/underflow is visible and
  // the result can be clamped instead of wrapping.
  logic [FREQ_W:0]      sum_w, diff_w, restart_w;
  logic [FREQ_W-1:0]    up_val, dn_val, restart_val;
  logic                 degen;

  always_comb begin
    sum_w       = {1'b0, freq_q} + {1'b0, f_step_q};
    diff_w      = {1'b0, freq_q} - {1'b0, f_step_q};
    restart_w   = {1'b0, f_start_q} + {1'b0, f_step_q};
    up_val      = (sum_w > {1'b0, f_stop_q}) ? f_stop_q : sum_w[FREQ_W-1:0];
    // diff_w MSB set means the subtraction went below zero.
    dn_val      = (diff_w[FREQ_W] || (diff_w[FREQ_W-1:0] < f_start_q))
                  ? f_start_q : diff_w[FREQ_W-1:0];
    restart_val = (restart_w > {1'b0, f_stop_q}) ? f_stop_q : restart_w[FREQ_W-1:0];
    // With an empty range the word is pinned and every step is an end event.
    degen       = (f_start_q >= f_stop_q);
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    freq_d      = freq_q;
    dwell_cnt_d = dwell_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    mode_d      = mode_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;

    if (ena) begin
      done_d = 1'b0;
      if (stop) begin
        // Abort: phase and frequency keep their last values.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              mode_d      = mode;
              f_start_d   = f_start;
              f_stop_d    = f_stop;
              f_step_d    = f_step;
              dwell_d     = dwell;
              phase_d     = '0;
              dwell_cnt_d = '0;
              busy_d      = 1'b1;
              if ((mode == MODE_SINGLE_DN) && (f_start < f_stop)) begin
                freq_d = f_stop;
              end else begin
                freq_d = f_start;
              end
              state_d = (mode == MODE_SINGLE_DN) ? ST_DOWN : ST_UP;
            end
          end

          ST_UP, ST_DOWN: begin
            phase_d = phase_q + PHASE_W'(freq_q);
            if (dwell_cnt_q != dwell_q) begin
              dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end else begin
              dwell_cnt_d = '0;
              if (degen) begin
                freq_d = f_start_q;
                done_d = 1'b1;
                if ((mode_q == MODE_SINGLE_UP) || (mode_q == MODE_SINGLE_DN)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_UP) begin
                if (freq_q < f_stop_q) begin
                  freq_d = up_val;
                end else begin
                  case (mode_q)
                    MODE_REPEAT_UP: begin
                      freq_d = f_start_q;
                      done_d = 1'b1;
                    end
                    MODE_TRIANGLE: begin
                      // Turn around and take the first down step now.
                      state_d = ST_DOWN;
                      freq_d  = dn_val;
                    end
                    default: begin
                      state_d = ST_IDLE;
                      busy_d  = 1'b0;
                      done_d  = 1'b1;
                    end
                  endcase
                end
              end else begin
                if (freq_q > f_start_q) begin
                  freq_d = dn_val;
                end else if (mode_q == MODE_TRIANGLE) begin
                  state_d = ST_UP;
                  freq_d  = restart_val;
                  done_d  = 1'b1;
                end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              end
            end
          end

          default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      freq_q      <= '0;
      dwell_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      freq_q      <= freq_d;
      dwell_cnt_q <= dwell_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign freq_out = freq_q;
  assign sq_out   = phase_q[PHASE_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_saw
      assign saw_out[gi] = phase_q[PHASE_W-OUT_W+gi];
    end
  endgenerate

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Testbench for chirp_sweep_gen: table-driven sweep vectors followed by
// hand-written sequences for phase wrap, clock-enable freeze and async reset.
module tb_chirp_sweep_gen;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [11:0] f_start;
  logic [11:0] f_stop;
  logic [11:0] f_step;
  logic [7:0]  dwell;
  logic        busy;
  logic        done;
  logic [11:0] freq_out;
  logic [7:0]  saw_out;
  logic        sq_out;

  int total = 0;
  int bad   = 0;

  chirp_sweep_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .busy     (busy),
    .done     (done),
    .freq_out (freq_out),
    .saw_out  (saw_out),
    .sq_out   (sq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        st;
    logic        sp;
    logic [1:0]  m;
    logic [11:0] fs;
    logic [11:0] fe;
    logic [11:0] fstep;
    logic [7:0]  dw;
    logic [11:0] exp_freq;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic st, input logic sp, input logic [1:0] m,
                               input logic [11:0] fs, input logic [11:0] fe,
                               input logic [11:0] fstep, input logic [7:0] dw,
                               input logic [11:0] ef, input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.sp = sp; v.m = m; v.fs = fs; v.fe = fe; v.fstep = fstep; v.dw = dw;
    v.exp_freq = ef; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [11:0] fs, input logic [11:0] fe,
                         input logic [11:0] fstep, input logic [7:0] dw);
    mode = m; f_start = fs; f_stop = fe; f_step = fstep; dwell = dw;
  endtask

  logic [15:0] exp_phase;
  logic [11:0] exp_freq;
  int          exp_cnt;
  int          k;

  initial begin
    // Test 1: mode 0, dwell 1, each value held two cycles
    vecs.push_back(mkv(1, 0, 0, 100, 130, 10, 1, 100, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 100, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 110, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 110, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 120, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 120, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 130, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 130, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 130, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 100, 130, 10, 1, 130, 0, 0));
    // Test 2: mode 0, last step clamped at f_stop
    vecs.push_back(mkv(1, 0, 0, 100, 125, 10, 0, 100, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 125, 10, 0, 110, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 125, 10, 0, 120, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 125, 10, 0, 125, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 100, 125, 10, 0, 125, 0, 1));
    // Test 3: mode 2 triangle, done on each 10->20 turn
    vecs.push_back(mkv(1, 0, 2, 10, 30, 10, 0, 10, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 30, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 10, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 1, 1));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 30, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 10, 1, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 1, 1));
    // start with a different config while busy: ignored
    vecs.push_back(mkv(1, 0, 0, 500, 900, 1, 0, 30, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 500, 900, 1, 0, 20, 1, 0));
    // stop: busy drops next edge, no done, frequency holds
    vecs.push_back(mkv(0, 1, 2, 10, 30, 10, 0, 20, 0, 0));
    vecs.push_back(mkv(0, 0, 2, 10, 30, 10, 0, 20, 0, 0));
    // stop and start together from idle: stop wins
    vecs.push_back(mkv(1, 1, 0, 77, 99, 1, 0, 20, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 77, 99, 1, 0, 20, 0, 0));
    // Degenerate mode 3 (f_start > f_stop): pinned at f_start, ends after dwell+1
    vecs.push_back(mkv(1, 0, 3, 50, 40, 5, 1, 50, 1, 0));
    vecs.push_back(mkv(0, 0, 3, 50, 40, 5, 1, 50, 1, 0));
    vecs.push_back(mkv(0, 0, 3, 50, 40, 5, 1, 50, 0, 1));
    vecs.push_back(mkv(0, 0, 3, 50, 40, 5, 1, 50, 0, 0));
    // Mode 3 down sweep, step underflow clamps to f_start
    vecs.push_back(mkv(1, 0, 3, 10, 30, 15, 0, 30, 1, 0));
    vecs.push_back(mkv(0, 0, 3, 10, 30, 15, 0, 15, 1, 0));
    vecs.push_back(mkv(0, 0, 3, 10, 30, 15, 0, 10, 1, 0));
    vecs.push_back(mkv(0, 0, 3, 10, 30, 15, 0, 10, 0, 1));

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset.freq", 32'(freq_out), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.saw", 32'(saw_out), 0);
    chk("reset.sq", 32'(sq_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      set_cfg(vecs[i].m, vecs[i].fs, vecs[i].fe, vecs[i].fstep, vecs[i].dw);
      start = vecs[i].st;
      stop  = vecs[i].sp;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      $display("vec %0d: start=%0b stop=%0b freq=%0d busy=%0b done=%0b",
               i, vecs[i].st, vecs[i].sp, freq_out, busy, done);
      chk($sformatf("vec%0d.freq", i), 32'(freq_out), 32'(vecs[i].exp_freq));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].exp_done));
    end

    // Test 4: mode 1 with fixed word 4000, phase wraps; done every 3 enabled cycles.
    // ena dropped right after a done pulse to confirm done holds while frozen.
    set_cfg(1, 4000, 4000, 7, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int i = 1; i <= 45; i++) begin
      ena = !(i == 4 || i == 5 || i == 20);
      @(negedge clk);
      if (ena) k++;
      exp_phase = 16'(k * 4000);
      $display("wrap cyc %0d: ena=%0b saw=%0d sq=%0b done=%0b", i, ena, saw_out, sq_out, done);
      chk($sformatf("wrap%0d.saw", i), 32'(saw_out), 32'(exp_phase[15:8]));
      chk($sformatf("wrap%0d.sq", i), 32'(sq_out), 32'(exp_phase[15]));
      chk($sformatf("wrap%0d.done", i), 32'(done), 32'((k > 0) && (k % 3 == 0)));
      chk($sformatf("wrap%0d.freq", i), 32'(freq_out), 4000);
    end
    ena = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("wrap.stop.busy", 32'(busy), 0);

    // Test 5: ena low for 5 cycles mid-sweep (stop during freeze is ignored)
    set_cfg(0, 1000, 2000, 100, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_phase = 16'd0; exp_freq = 12'd1000; exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      ena  = !(i >= 6 && i <= 10);
      stop = (i == 8);
      @(negedge clk);
      stop = 1'b0;
      if (ena) begin
        exp_phase = exp_phase + 16'(exp_freq);
        if (exp_cnt == 1) begin
          exp_cnt  = 0;
          exp_freq = (exp_freq + 12'd100 > 12'd2000) ? 12'd2000 : exp_freq + 12'd100;
        end else begin
          exp_cnt++;
        end
      end
      $display("freeze cyc %0d: ena=%0b freq=%0d saw=%0d busy=%0b", i, ena, freq_out, saw_out, busy);
      chk($sformatf("freeze%0d.freq", i), 32'(freq_out), 32'(exp_freq));
      chk($sformatf("freeze%0d.saw", i), 32'(saw_out), 32'(exp_phase[15:8]));
      chk($sformatf("freeze%0d.busy", i), 32'(busy), 1);
      chk($sformatf("freeze%0d.done", i), 32'(done), 0);
    end
    ena = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("freeze.stop.busy", 32'(busy), 0);

    // Test 6: async reset in the middle of a mode 3 sweep
    set_cfg(3, 100, 300, 50, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst.pre.freq", 32'(freq_out), 250);
    chk("arst.pre.saw", 32'(saw_out), 6);
    #1 rst_n = 1'b0;
    #1;
    $display("arst: freq=%0d busy=%0b done=%0b saw=%0d sq=%0b", freq_out, busy, done, saw_out, sq_out);
    chk("arst.freq", 32'(freq_out), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.saw", 32'(saw_out), 0);
    chk("arst.sq", 32'(sq_out), 0);
    @(negedge clk);
    chk("arst.held.done", 32'(done), 0);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("arst.restart.freq", 32'(freq_out), 300);
    chk("arst.restart.busy", 32'(busy), 1);
    chk("arst.restart.saw", 32'(saw_out), 0);
    @(negedge clk);
    chk("arst.restart.saw1", 32'(saw_out), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
